// File: rtl/bin2bcd4_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD
// converter that feeds the 4-digit 7-segment multiplexer.
//   state_t  : FSM state encoding (IDLE / SHIFT / DONE)
//   MAX_VAL  : largest value the 4-digit display can show
//   DIGITS   : number of BCD digits produced
//   BCD_W    : width of the packed BCD working register
package bin2bcd4_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned MAX_VAL = 9999;
  localparam int          DIGITS  = 4;
  localparam int          BCD_W   = 16;

endpackage

// File: rtl/bin2bcd4_seq_digit_adj.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5 or
// more, so the following left shift carries correctly into the next digit.
//   digit_in  : current BCD nibble (0..9)
//   digit_out : corrected nibble, ready to be shifted
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Input is at most 9, so the sum is at most 12 and never wraps the nibble.
  assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin2bcd4_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Results are held in output registers that only change on the edge into
// DONE, so the downstream display multiplexer never sees partial digits.
// Inputs above MAX_VAL saturate to 9999 and raise ovf.
//   clk   : system clock, rising edge
//   rst   : synchronous, active-high reset
//   start : conversion request, only looked at in IDLE
//   bin   : unsigned value, captured when start is accepted
//   busy  : high whenever the FSM is not in IDLE
//   done  : one-cycle pulse, new result valid on dig0..dig3
//   ovf   : last accepted value exceeded MAX_VAL
//   dig0..dig3 : BCD units, tens, hundreds, thousands
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | BIN_W adjust-and-shift iterations, one per clock
// DONE  | result just published; done pulses for this one cycle
module bin2bcd4_seq
  import bin2bcd4_seq_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       dig0,
  output logic [3:0]       dig1,
  output logic [3:0]       dig2,
  output logic [3:0]       dig3
);

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic               ovf_q, ovf_d;
  logic               last_iter;
  logic               over_max;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (bcd_q[4*g +: 4]),
      .digit_out (bcd_adj[4*g +: 4])
    );
  end

  assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));
  assign over_max  = (32'(bin) > MAX_VAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      digits_q   <= digits_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SHIFT;
          // MAX_VAL only fits when BIN_W is wide enough to exceed it, which
          // is also the only case where over_max can be true.
          shreg_d    = over_max ? BIN_W'(MAX_VAL) : bin;
          ovf_pend_d = over_max;
          bcd_d      = '0;
          cnt_d      = '0;
        end
      end
      SHIFT: begin
        {bcd_d, shreg_d} = {bcd_adj[BCD_W-2:0], shreg_q, 1'b0};
        cnt_d            = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d  = DONE;
          // Publish the post-shift value directly so digits change on the
          // edge into DONE rather than one cycle later.
          digits_d = {bcd_adj[BCD_W-2:0], shreg_q[BIN_W-1]};
          ovf_d    = ovf_pend_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign ovf  = ovf_q;
  assign dig0 = digits_q[3:0];
  assign dig1 = digits_q[7:4];
  assign dig2 = digits_q[11:8];
  assign dig3 = digits_q[15:12];

endmodule
